counter7sd_input_ctrl: RTL



---
 rtl/counter7sd_pkg.sv | 13 +
 rtl/counter7sd_input_ctrl_btn_debounce.sv | 54 +++++
 rtl/counter7sd_input_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/counter7sd_pkg.sv
// Shared polarity constants and pause-button state type for the seven-segment counter controls.
package counter7sd_pkg;

    localparam logic PAUSE_ACTIVE = 1'b0;
    localparam logic REVERSE_DOWN = 1'b1;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_DOWN = 2'd1,
        P_LONG = 2'd2
    } pause_state_e;

endpackage

// File: rtl/counter7sd_input_ctrl_btn_debounce.sv
// Two-flop synchroniser plus counting debouncer; emits one-cycle press/release pulses with each level flip.
module btn_debounce
    import counter7sd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          differs, flip;

    // The counter holds the number of samples already seen disagreeing; the Nth one flips the level.
    always_comb begin
        differs   = (sync_q[1] != level_q);
        flip      = differs && (cnt_q == CNT_LAST);
        cnt_d     = (differs && !flip) ? cnt_q + 1'b1 : '0;
        level_d   = level_q ^ flip;
        press_d   = flip && !level_q;
        release_d = flip && level_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_raw_i};
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/counter7sd_input_ctrl.sv
// Button conditioning, step strobe and hold request for the seven-segment counter.
// Define LONG_PRESS_HOLD_EN to turn a long pause press into a one-cycle HOLD request.
module counter7sd_input_ctrl
    import counter7sd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TICK_DIV        = 50000000,
    parameter int unsigned LONG_CYCLES     = 100000000
) (
    input  logic clock,
    input  logic reset,
    input  logic pause_btn,
    input  logic reverse_btn,
    output logic pause,
    output logic reverse,
    output logic tick,
    output logic hold_n
);
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] DIV_LAST = TW'(TICK_DIV - 1);

    // Bit 0 is the pause button, bit 1 the reverse button.
    logic [1:0]    btn_raw;
    logic [1:0]    btn_level_unused;
    logic [1:0]    btn_press;
    logic [1:0]    btn_release;
    logic [TW-1:0] div_q, div_d;
    logic          pause_q, pause_d;
    logic          reverse_q, reverse_d;

    assign btn_raw = {reverse_btn, pause_btn};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clock    (clock),
            .reset    (reset),
            .btn_raw_i(btn_raw[gi]),
            .level_o  (btn_level_unused[gi]),
            .press_o  (btn_press[gi]),
            .release_o(btn_release[gi])
        );
    end

    // The strobe is left ungated; the counter itself decides whether to step while paused.
    assign tick      = (div_q == DIV_LAST);
    assign div_d     = tick ? '0 : div_q + 1'b1;
    assign reverse_d = reverse_q ^ btn_press[1];

`ifdef LONG_PRESS_HOLD_EN
    localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    pause_state_e  state_q, state_d;
    logic [LW-1:0] long_q, long_d;
    logic          hold_n_q, hold_n_d;
    logic          rev_release_unused;

    assign rev_release_unused = btn_release[1];

    // A release that lands on the same cycle as the long-press threshold still counts as a short press.
    always_comb begin
        state_d  = state_q;
        long_d   = long_q;
        pause_d  = pause_q;
        hold_n_d = 1'b1;
        case (state_q)
            P_IDLE: begin
                if (btn_press[0]) begin
                    state_d = P_DOWN;
                    long_d  = '0;
                end
            end
            P_DOWN: begin
                if (btn_release[0]) begin
                    pause_d = ~pause_q;
                    state_d = P_IDLE;
                end else if (long_q == LONG_LAST) begin
                    hold_n_d = 1'b0;
                    state_d  = P_LONG;
                end else begin
                    long_d = long_q + 1'b1;
                end
            end
            P_LONG: begin
                if (btn_release[0]) begin
                    state_d = P_IDLE;
                end
            end
            default: state_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= P_IDLE;
            long_q   <= '0;
            hold_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            long_q   <= long_d;
            hold_n_q <= hold_n_d;
        end
    end

    assign hold_n = hold_n_q;
`else
    localparam int unsigned LONG_CYCLES_UNUSED = LONG_CYCLES;
    logic release_unused;

    assign release_unused = ^btn_release;
    assign pause_d        = pause_q ^ btn_press[0];
    assign hold_n         = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q     <= '0;
            pause_q   <= ~PAUSE_ACTIVE;
            reverse_q <= ~REVERSE_DOWN;
        end else begin
            div_q     <= div_d;
            pause_q   <= pause_d;
            reverse_q <= reverse_d;
        end
    end

    assign pause   = pause_q;
    assign reverse = reverse_q;

endmodule
